// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: FSM states and default strobe timing.
package rtc_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        A_SET = 4'd1,
        A_STB = 4'd2,
        A_HLD = 4'd3,
        GAP   = 4'd4,
        D_SET = 4'd5,
        D_STB = 4'd6,
        D_HLD = 4'd7,
        DONE  = 4'd8
    } rtc_state_e;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_PULSE_DEF = 4;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_GAP_DEF   = 1;

    // Largest phase length sets the width of the shared phase counter.
    function automatic int unsigned t_max(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that marks the last cycle of the current bus phase.
module rtc_phase_timer
    import rtc_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_c_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Address-then-data single-byte transactions on the RTC multiplexed A/D bus.
// Every pin is registered from the next state, so pins change on the same edge as the state.
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] bus_in_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [7:0] bus_out_o,
    output logic       bus_oe_o,
    output logic       ad_sel_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o
);

    localparam int unsigned T_MAX = t_max(T_SETUP, T_PULSE, T_HOLD, T_GAP);
    localparam int unsigned CW    = $clog2(T_MAX) + 1;

    rtc_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    logic          busy_q, done_q, bus_oe_q, ad_sel_q, cs_n_q, rd_n_q, wr_n_q;
    logic [7:0]    rdata_q, bus_out_q;

    function automatic logic [CW-1:0] phase_load(input rtc_state_e st);
        case (st)
            A_SET, D_SET: return CW'(T_SETUP - 1);
            A_STB, D_STB: return CW'(T_PULSE - 1);
            A_HLD, D_HLD: return CW'(T_HOLD - 1);
            GAP:          return CW'(T_GAP - 1);
            default:      return '0;
        endcase
    endfunction

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_c_o   (tmr_zero)
    );

    // Next state, request capture and phase-counter reload.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = A_SET;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            A_SET:   if (tmr_zero) state_d = A_STB;
            A_STB:   if (tmr_zero) state_d = A_HLD;
            A_HLD:   if (tmr_zero) state_d = GAP;
            GAP:     if (tmr_zero) state_d = D_SET;
            D_SET:   if (tmr_zero) state_d = D_STB;
            D_STB:   if (tmr_zero) state_d = D_HLD;
            D_HLD:   if (tmr_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tmr_load = (state_d != state_q);
        tmr_val  = phase_load(state_d);
    end

    // State, latched request and registered pin drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
            bus_out_q <= 8'h00;
            bus_oe_q  <= 1'b0;
            ad_sel_q  <= 1'b1;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (state_q == D_STB && tmr_zero && !we_q) begin
                rdata_q <= bus_in_i;
            end
            busy_q   <= !(state_d inside {IDLE, DONE});
            done_q   <= (state_d == DONE);
            ad_sel_q <= !(state_d inside {GAP, D_SET, D_STB, D_HLD});
            cs_n_q   <= (state_d inside {IDLE, GAP, DONE});
            bus_oe_q <= (state_d inside {A_SET, A_STB, A_HLD}) ||
                        (we_d && (state_d inside {D_SET, D_STB, D_HLD}));
            if (state_d inside {A_SET, A_STB, A_HLD}) begin
                bus_out_q <= addr_d;
            end else if (we_d && (state_d inside {D_SET, D_STB, D_HLD})) begin
                bus_out_q <= wdata_d;
            end
            wr_n_q <= !((state_d == A_STB) || (state_d == D_STB && we_d));
            rd_n_q <= !(state_d == D_STB && !we_d);
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign bus_out_o = bus_out_q;
    assign bus_oe_o  = bus_oe_q;
    assign ad_sel_o  = ad_sel_q;
    assign cs_n_o    = cs_n_q;
    assign rd_n_o    = rd_n_q;
    assign wr_n_o    = wr_n_q;

endmodule
